// File: rtl/regfile_dump_reader.sv
// Purpose: walks the register file's read port and streams each masked register out as (addr, data) beats.
// Latency: for the first masked register, start to out_valid takes READ_LAT+2 edges, plus one edge per
//          unmasked register skipped before it. Throughput is one word per READ_LAT+3 cycles.
// Backpressure: a presented word is held stable until out_ready; the scan does not advance while it waits.
//
// Ports:
//   clock_reg, reset      rising-edge clock, asynchronous active-low reset
//   start, mask           begin a dump (sampled only when idle); mask bit i selects register i
//   rd_addr, rd_data      register file read port (registered read, READ_LAT cycles)
//   out_data/out_addr     captured word and its address
//   out_valid/out_ready   output handshake
//   busy, done            busy is high whenever not idle; done pulses for one cycle at the end of a dump
module regfile_dump_reader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8,
  parameter int READ_LAT = 1
) (
  input  logic                clock_reg,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_REGS-1:0] mask,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEEK    = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_PRESENT = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_valid_q, out_valid_d;

  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = mask;
          addr_d  = '0;
          state_d = S_SEEK;
        end
      end

      S_SEEK: begin
        if (mask_q[addr_q]) begin
          // Load the address on the way into ISSUE so the file sees it for the whole ISSUE cycle.
          rd_addr_d = addr_q;
          state_d   = S_ISSUE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_FINISH;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      S_ISSUE: begin
        // The file samples rd_addr at the end of this cycle; count its read latency from there.
        cnt_d   = CNT_W'(READ_LAT);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_data_d  = rd_data;
          out_addr_d  = addr_q;
          out_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = S_FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_SEEK;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr   = rd_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Purpose: exercises regfile_dump_reader at read latencies 1 and 3 against a register file model.
// Latency: n/a (testbench).
// Backpressure: out_ready is driven high, stalled per beat, or randomized.
module tb_regfile_dump_reader;

  logic clock_reg = 1'b0;
  always #5 clock_reg = ~clock_reg;

  logic       rst_n;
  logic       start;
  logic       sel;
  logic [7:0] mask;
  logic       out_ready;

  logic [2:0] rd_addr1, rd_addr3, out_addr1, out_addr3;
  logic [7:0] rd_data1, rd_data3, out_data1, out_data3;
  logic       out_valid1, out_valid3, busy1, busy3, done1, done3;
  logic       start1, start3;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  regfile_dump_reader #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .READ_LAT(1)) dut (
    .clock_reg(clock_reg), .reset(rst_n), .start(start1), .mask(mask),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_data(out_data1), .out_addr(out_addr1),
    .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .done(done1)
  );

  regfile_dump_reader #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8), .READ_LAT(3)) dut3 (
    .clock_reg(clock_reg), .reset(rst_n), .start(start3), .mask(mask),
    .rd_addr(rd_addr3), .rd_data(rd_data3), .out_data(out_data3), .out_addr(out_addr3),
    .out_valid(out_valid3), .out_ready(out_ready), .busy(busy3), .done(done3)
  );

  // Register file models: contents plus a read pipeline of the stated latency.
  logic [7:0] regs1 [8];
  logic [7:0] regs3 [8];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  always @(posedge clock_reg) begin
    pipe1    <= regs1[rd_addr1];
    pipe3[0] <= regs3[rd_addr3];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rd_data1 = pipe1;
  assign rd_data3 = pipe3[2];

  // View of whichever instance is under test.
  logic       v_valid, v_busy, v_done;
  logic [7:0] v_data;
  logic [2:0] v_addr;
  assign v_valid = sel ? out_valid3 : out_valid1;
  assign v_busy  = sel ? busy3 : busy1;
  assign v_done  = sel ? done3 : done1;
  assign v_data  = sel ? out_data3 : out_data1;
  assign v_addr  = sel ? out_addr3 : out_addr1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_regs(input bit incrementing);
    for (int i = 0; i < 8; i++) begin
      regs1[i] = incrementing ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
      regs3[i] = incrementing ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));
    end
  endtask

  // One complete dump on the selected instance, checked against the mask/register model.
  task automatic run_dump(input string tag, input logic [7:0] m, input int stall_n,
                          input bit rnd_ready, input bit poke_start);
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int   lat, lo, hi, cyc, first_v, done_cyc, done_cnt, acc_cyc, busy_bad, post_bad, stall_left;
    int   exp_first, exp_done;
    bit   prev_v, prev_acc, finished;
    logic [7:0] hd;
    logic [2:0] ha;

    lat = sel ? 3 : 1;
    lo  = -1;
    hi  = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_q.push_back({5'd0, 3'(i), (sel ? regs3[i] : regs1[i])});
        if (lo < 0) lo = i;
        hi = i;
      end
    end

    out_ready = 1'b1;
    mask      = m;
    start     = 1'b1;
    @(negedge clock_reg);
    start      = 1'b0;
    cyc        = 0;
    first_v    = -1;
    done_cyc   = -1;
    done_cnt   = 0;
    acc_cyc    = -1;
    busy_bad   = 0;
    post_bad   = 0;
    stall_left = 0;
    prev_v     = 1'b0;
    prev_acc   = 1'b0;
    finished   = 1'b0;
    hd         = '0;
    ha         = '0;

    while (!finished && cyc < 400) begin
      if (prev_v && !prev_acc) begin
        check({tag, "_hold_valid"}, 32'(v_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(v_data), 32'(hd));
        check({tag, "_hold_addr"}, 32'(v_addr), 32'(ha));
      end
      if (v_valid && first_v < 0) first_v = cyc;
      if (v_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 && !v_busy) busy_bad++;
      if (done_cyc >= 0 && cyc > done_cyc) begin
        if (v_busy || v_done || v_valid) post_bad++;
        if (cyc >= done_cyc + 3) finished = 1'b1;
      end

      start = (poke_start && v_busy && !v_done && ($urandom_range(0, 2) == 0)) ? 1'b1 : 1'b0;
      if (v_valid) begin
        if (!prev_v) stall_left = stall_n;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end

      prev_acc = v_valid && out_ready;
      if (prev_acc) begin
        got_q.push_back({5'd0, v_addr, v_data});
        acc_cyc = cyc;
      end
      prev_v = v_valid;
      hd     = v_data;
      ha     = v_addr;

      if (!finished) begin
        @(negedge clock_reg);
        cyc++;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;

    if (!finished) check({tag, "_timeout"}, 32'd1, 32'd0);

    // Timing from the rules: SEEK walks one address per cycle, then ISSUE, then READ_LAT wait cycles.
    exp_first = (lo < 0) ? -1 : lat + 2 + lo;
    exp_done  = (hi < 0) ? 8 : acc_cyc + 1 + (7 - hi);

    check({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_first_valid"}, 32'(first_v), 32'(exp_first));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    check({tag, "_idle_after"}, 32'(post_bad), 32'd0);
  endtask

  task automatic reset_midway();
    int  n;
    bit  hit;
    sel = 1'b0;
    fill_regs(1'b0);
    mask      = 8'hFF;
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clock_reg);
    start = 1'b0;
    n     = 0;
    hit   = 1'b0;
    while (!hit && n < 200) begin
      if (v_valid && v_addr == 3'd3) begin
        hit       = 1'b1;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        @(negedge clock_reg);
        n++;
      end
    end
    check("rst_reach_addr3", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid1), 32'd0);
    check("rst_data", 32'(out_data1), 32'd0);
    check("rst_addr", 32'(out_addr1), 32'd0);
    check("rst_rd_addr", 32'(rd_addr1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock_reg);
      check("rst_hold_done", 32'(done1), 32'd0);
    end
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clock_reg);
    check("rst_no_done", 32'(done1), 32'd0);
    check("rst_idle", 32'(busy1), 32'd0);
    run_dump("rst_fresh", 8'hFF, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    sel       = 1'b0;
    mask      = 8'h00;
    out_ready = 1'b0;
    fill_regs(1'b1);
    repeat (3) @(negedge clock_reg);
    check("reset_valid", 32'(out_valid1), 32'd0);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_outs", 32'({out_data1, out_addr1, rd_addr1}), 32'd0);
    check("reset3_outs", 32'({out_valid3, busy3, done3, out_data3, out_addr3, rd_addr3}), 32'd0);
    rst_n = 1'b1;
    @(negedge clock_reg);

    run_dump("full", 8'hFF, 0, 1'b0, 1'b0);
    run_dump("sparse", 8'b1000_0101, 0, 1'b0, 1'b0);
    fill_regs(1'b0);
    run_dump("stall", 8'hFF, 5, 1'b0, 1'b0);
    run_dump("empty", 8'h00, 0, 1'b0, 1'b0);
    reset_midway();
    for (int k = 0; k < 4; k++) begin
      fill_regs(1'b0);
      run_dump("rand", 8'($urandom_range(0, 255)), 0, 1'b1, 1'b0);
    end

    sel = 1'b1;
    fill_regs(1'b0);
    run_dump("lat3", 8'hFF, 0, 1'b0, 1'b1);
    fill_regs(1'b0);
    run_dump("lat3_rand", 8'($urandom_range(0, 255)), 0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
